// File: rtl/iir_tdm_pkg.sv
// Shared constants, types and fixed-point helpers for the time-multiplexed DF-II IIR.
// IIR_SATURATE_EN selects saturating narrowing; when undefined results wrap (two's complement).
package iir_tdm_pkg;

   localparam int W_DEFAULT    = 14;
   localparam int N_CH_DEFAULT = 4;
   localparam int WIDE         = 64;

   // Wide intermediate wide enough for any W up to 31 without loss.
   typedef logic signed [WIDE-1:0]      wide_t;
   typedef logic signed [W_DEFAULT-1:0] state_t;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Signed Q1.(w-1) multiply; the arithmetic shift floors toward minus infinity.
   function automatic wide_t qmul(input wide_t a, input wide_t b, input int w);
      return (a * b) >>> (w - 1);
   endfunction

   function automatic wide_t narrow(input wide_t v, input int w);
`ifdef IIR_SATURATE_EN
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
`else
      // Keep the low w bits and sign-extend them back to full width.
      return (v <<< (WIDE - w)) >>> (WIDE - w);
`endif
   endfunction

endpackage

// File: rtl/iir_tdm_df2_if.sv
// Sample-stream interface of the TDM IIR: tagged input samples, shared coefficients, tagged outputs.
interface iir_tdm_df2_if import iir_tdm_pkg::*; #(
   parameter int W    = W_DEFAULT,
   parameter int N_CH = N_CH_DEFAULT
) ();

   localparam int CW = ch_width(N_CH);

   logic                VIN;
   logic signed [W-1:0] DIN;
   logic [CW-1:0]       CH_IN;
   logic                CLR;
   logic signed [W-1:0] B0;
   logic signed [W-1:0] B1;
   logic signed [W-1:0] A1;
   logic signed [W-1:0] DOUT;
   logic                VOUT;
   logic [CW-1:0]       CH_OUT;

   // Source/sink side of the filter.
   modport master (
      output VIN, DIN, CH_IN, CLR, B0, B1, A1,
      input  DOUT, VOUT, CH_OUT
   );

   // Filter side.
   modport slave (
      input  VIN, DIN, CH_IN, CLR, B0, B1, A1,
      output DOUT, VOUT, CH_OUT
   );

endinterface

// File: rtl/iir_state_rf.sv
// Per-channel DF-II state register file: one combinational read port, one write port, clear-all.
module iir_state_rf import iir_tdm_pkg::*; #(
   parameter  int W    = W_DEFAULT,
   parameter  int N_CH = N_CH_DEFAULT,
   localparam int CW   = ch_width(N_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                we,
   input  logic [CW-1:0]       waddr,
   input  logic signed [W-1:0] wdata,
   input  logic [CW-1:0]       raddr,
   output logic signed [W-1:0] rdata
);

   logic signed [W-1:0] mem [N_CH];

   // NOTE: this storage is reset because every channel state must read zero after reset;
   // a plain RAM macro could not be used here for that reason.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) mem[c] <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            // The write of the sample in flight takes priority over clear-all on its own entry.
            if (we && (int'(waddr) == c)) mem[c] <= wdata;
            else if (clr)                 mem[c] <= '0;
         end
      end
   end

   // NOTE: rdata gets a default first so no path through this block can infer a latch.
   always_comb begin
      rdata = '0;
      if (int'(raddr) < N_CH) rdata = mem[raddr];
   end

endmodule

// File: rtl/iir_tdm_df2.sv
// First-order direct-form-II IIR time-multiplexed over N_CH channels; 2-cycle latency, 1 sample/cycle.
// Overflow handling selected by IIR_SATURATE_EN (saturate) or its absence (wrap).
module iir_tdm_df2 import iir_tdm_pkg::*; #(
   parameter int W    = W_DEFAULT,
   parameter int N_CH = N_CH_DEFAULT
) (
   input  logic          CLK,
   input  logic          RST_n,
   iir_tdm_df2_if.slave  bus
);

   localparam int CW = ch_width(N_CH);

   logic                in_ok;
   logic signed [W-1:0] rd_w;
   logic signed [W-1:0] wp;
   logic signed [W-1:0] w_new;
   logic signed [W-1:0] y_new;
   wide_t               w_sum;
   wide_t               y_acc;

   logic                s1_valid;
   logic signed [W-1:0] s1_w;
   logic signed [W-1:0] s1_wp;
   logic [CW-1:0]       s1_ch;

   iir_state_rf #(.W(W), .N_CH(N_CH)) u_rf (
      .clk   (CLK),
      .rst_n (RST_n),
      .clr   (bus.CLR),
      .we    (in_ok),
      .waddr (bus.CH_IN),
      .wdata (w_new),
      .raddr (bus.CH_IN),
      .rdata (rd_w)
   );

   always_comb begin
      in_ok = bus.VIN && (int'(bus.CH_IN) < N_CH);
      // A sample arriving with CLR sees its channel already cleared.
      wp    = bus.CLR ? '0 : rd_w;
      w_sum = wide_t'(bus.DIN) - qmul(wide_t'(bus.A1), wide_t'(wp), W);
      w_new = W'(narrow(w_sum, W));
      // Sum both products before the shift so the floor applies once to the total.
      y_acc = wide_t'(bus.B0) * wide_t'(s1_w) + wide_t'(bus.B1) * wide_t'(s1_wp);
      y_new = W'(narrow(y_acc >>> (W - 1), W));
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         s1_valid   <= 1'b0;
         s1_w       <= '0;
         s1_wp      <= '0;
         s1_ch      <= '0;
         bus.DOUT   <= '0;
         bus.VOUT   <= 1'b0;
         bus.CH_OUT <= '0;
      end else begin
         s1_valid <= in_ok;
         if (in_ok) begin
            s1_w  <= w_new;
            s1_wp <= wp;
            s1_ch <= bus.CH_IN;
         end
         bus.VOUT <= s1_valid;
         // DOUT and CH_OUT hold their last value while no sample emerges.
         if (s1_valid) begin
            bus.DOUT   <= y_new;
            bus.CH_OUT <= s1_ch;
         end
      end
   end

endmodule

// File: tb/tb_iir_tdm_df2.sv
// Scoreboard bench for iir_tdm_df2: a 4-channel and a 3-channel instance against an arithmetic model.
module tb_iir_tdm_df2;
   import iir_tdm_pkg::*;

   localparam int     W     = 14;
   localparam int     NA    = 4;
   localparam int     NB    = 3;
   localparam int     CWA   = ch_width(NA);
   localparam int     CWB   = ch_width(NB);
   localparam longint FS    = longint'(1) << (W - 1);
   localparam int     NOEXP = 32'h7fffffff;

   typedef struct {
      int ch;
      int y;
   } exp_t;

   logic CLK = 1'b0;
   logic RST_n = 1'b0;
   always #5 CLK = ~CLK;

   iir_tdm_df2_if #(.W(W), .N_CH(NA)) bus_a ();
   iir_tdm_df2_if #(.W(W), .N_CH(NB)) bus_b ();

   iir_tdm_df2 #(.W(W), .N_CH(NA)) dut_a (.CLK(CLK), .RST_n(RST_n), .bus(bus_a));
   iir_tdm_df2 #(.W(W), .N_CH(NB)) dut_b (.CLK(CLK), .RST_n(RST_n), .bus(bus_b));

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   int   st[2][4];
   int   cb0, cb1, ca1;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint floor_div(input longint n, input longint d);
      longint q;
      q = n / d;
      if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
      return q;
   endfunction

   function automatic int fit(input longint v);
`ifdef IIR_SATURATE_EN
      if (v > FS - 1) return int'(FS - 1);
      if (v < -FS)    return int'(-FS);
      return int'(v);
`else
      longint m;
      m = ((v % (2 * FS)) + 2 * FS) % (2 * FS);
      return int'((m >= FS) ? m - 2 * FS : m);
`endif
   endfunction

   task automatic model_step(input int dut, input int ch, input int x, input bit clr,
                             output bit produces, output int y);
      int  n;
      int  wp;
      int  wn;
      n = (dut == 0) ? NA : NB;
      if (clr) for (int c = 0; c < 4; c++) st[dut][c] = 0;
      produces = 1'b0;
      y = 0;
      if (ch < n) begin
         wp = st[dut][ch];
         wn = fit(longint'(x) - floor_div(longint'(ca1) * wp, FS));
         y  = fit(floor_div(longint'(cb0) * wn + longint'(cb1) * wp, FS));
         st[dut][ch] = wn;
         produces = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      bus_a.VIN = 1'b0; bus_a.CLR = 1'b0;
      bus_b.VIN = 1'b0; bus_b.CLR = 1'b0;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Drives one sample for one cycle; a given exp_y overrides the model value.
   task automatic send(input int dut, input int ch, input int x, input bit clr,
                       input int exp_y = NOEXP);
      bit   p;
      int   y;
      exp_t e;
      model_step(dut, ch, x, clr, p, y);
      if (exp_y != NOEXP) y = exp_y;
      e.ch = ch;
      e.y  = y;
      bus_a.VIN = 1'b0; bus_a.CLR = 1'b0;
      bus_b.VIN = 1'b0; bus_b.CLR = 1'b0;
      if (dut == 0) begin
         if (p) q_a.push_back(e);
         bus_a.VIN = 1'b1; bus_a.DIN = W'(x); bus_a.CH_IN = CWA'(ch); bus_a.CLR = clr;
      end else begin
         if (p) q_b.push_back(e);
         bus_b.VIN = 1'b1; bus_b.DIN = W'(x); bus_b.CH_IN = CWB'(ch); bus_b.CLR = clr;
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic drain(input string tag);
      idle(1);
      for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) idle(1);
      check({tag, "_pending_a"}, longint'(q_a.size()), 0);
      check({tag, "_pending_b"}, longint'(q_b.size()), 0);
      q_a.delete();
      q_b.delete();
   endtask

   task automatic set_coef(input int b0, input int b1, input int a1);
      cb0 = b0; cb1 = b1; ca1 = a1;
      bus_a.B0 = W'(b0); bus_a.B1 = W'(b1); bus_a.A1 = W'(a1);
      bus_b.B0 = W'(b0); bus_b.B1 = W'(b1); bus_b.A1 = W'(a1);
      idle(2);
   endtask

   task automatic model_clear_all();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) st[d][c] = 0;
   endtask

   // Output monitor: every VOUT must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      exp_t e;
      if (RST_n && bus_a.VOUT === 1'b1) begin
         if (q_a.size() == 0) check("extra_vout_a", longint'(bus_a.VOUT), 0);
         else begin
            e = q_a.pop_front();
            check("dout_a", longint'(bus_a.DOUT), e.y);
            check("ch_out_a", longint'(bus_a.CH_OUT), e.ch);
         end
      end
      if (RST_n && bus_b.VOUT === 1'b1) begin
         if (q_b.size() == 0) check("extra_vout_b", longint'(bus_b.VOUT), 0);
         else begin
            e = q_b.pop_front();
            check("dout_b", longint'(bus_b.DOUT), e.y);
            check("ch_out_b", longint'(bus_b.CH_OUT), e.ch);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_a.DIN = '0; bus_a.CH_IN = '0;
      bus_b.DIN = '0; bus_b.CH_IN = '0;
      model_clear_all();
      set_coef(0, 0, 0);
      RST_n = 1'b0;
      idle(3);
      RST_n = 1'b1;
      check("reset_vout_a", longint'(bus_a.VOUT), 0);
      check("reset_dout_a", longint'(bus_a.DOUT), 0);
      check("reset_ch_a",   longint'(bus_a.CH_OUT), 0);
      check("reset_vout_b", longint'(bus_b.VOUT), 0);
      check("reset_dout_b", longint'(bus_b.DOUT), 0);
      check("reset_ch_b",   longint'(bus_b.CH_OUT), 0);

      // Pure gain of one half.
      set_coef(4096, 0, 0);
      send(0, 0, 1000, 1'b0, 500);
      drain("t1");

      // Impulse through a pole at one half.
      set_coef(4096, 0, -4096);
      send(0, 1, 2000, 1'b0, 1000);
      send(0, 1, 0, 1'b0, 500);
      send(0, 1, 0, 1'b0, 250);
      drain("t2");

      // Interleaved channels, starting from a clear issued with the first sample.
      send(0, 0, 800,  1'b1, 400);
      send(0, 1, 1600, 1'b0, 800);
      send(0, 2, 2400, 1'b0, 1200);
      send(0, 3, 3200, 1'b0, 1600);
      send(0, 0, 0, 1'b0, 200);
      send(0, 1, 0, 1'b0, 400);
      send(0, 2, 0, 1'b0, 600);
      send(0, 3, 0, 1'b0, 800);
      drain("t3");

      // State overflow.
      set_coef(4096, 0, -8192);
      send(0, 2, 8191, 1'b1, 4095);
`ifdef IIR_SATURATE_EN
      send(0, 2, 8191, 1'b0, 4095);
`else
      send(0, 2, 8191, 1'b0, -1);
`endif
      drain("t4");

      // Out-of-range channel on the 3-channel instance.
      set_coef(4096, 0, -4096);
      send(1, 0, 800,  1'b1, 400);
      send(1, 1, 1600, 1'b0, 800);
      send(1, 2, 2400, 1'b0, 1200);
      send(1, 3, 1000, 1'b0);
      send(1, 0, 0, 1'b0, 200);
      send(1, 1, 0, 1'b0, 400);
      send(1, 2, 0, 1'b0, 600);
      drain("t5");

      // Mid-stream reset.
      send(0, 1, 2000, 1'b1, 1000);
      drain("t6a");
      RST_n = 1'b0;
      idle(1);
      RST_n = 1'b1;
      model_clear_all();
      check("midrst_vout", longint'(bus_a.VOUT), 0);
      check("midrst_dout", longint'(bus_a.DOUT), 0);
      check("midrst_ch",   longint'(bus_a.CH_OUT), 0);
      send(0, 1, 0, 1'b0, 0);
      drain("t6b");

      // Mid-stream clear without a sample.
      send(0, 1, 2000, 1'b0, 1000);
      drain("t6c");
      bus_a.CLR = 1'b1;
      @(posedge CLK);
      #1;
      bus_a.CLR = 1'b0;
      for (int c = 0; c < 4; c++) st[0][c] = 0;
      send(0, 1, 0, 1'b0, 0);
      drain("t6d");

      // Randomized traffic on both instances against the model.
      for (int blk = 0; blk < 6; blk++) begin
         set_coef(int'($urandom_range(0, 16383)) - 8192,
                  int'($urandom_range(0, 16383)) - 8192,
                  int'($urandom_range(0, 16383)) - 8192);
         for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 16383)) - 8192,
                      ($urandom_range(0, 15) == 0));
         end
         drain("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
